// File: rtl/buffer_frame_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_reader_pkg
//  Description : Shared types and constants for the buffer frame reader.
//                - frame_state_e : reader FSM states
//                - frame_tag_t   : per-sample frame markers held in the FIFO
//                - OVERRUN_CNT_W : width of the optional overrun counter
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_reader_pkg;

    localparam int OVERRUN_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } frame_state_e;

    // Marker half of a FIFO entry. The data word is concatenated in front of
    // it by the reader, because a package type cannot follow the reader's
    // DATA_WIDTH parameter.
    typedef struct packed {
        logic first;
        logic last;
    } frame_tag_t;

    // Width of a counter/pointer that must hold values 0..n-1, never 0 bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : frame_reader_pkg
`default_nettype wire

// File: rtl/buffer_frame_reader_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered occupancy count.
//                A push into a full FIFO is accepted only when a pop happens
//                in the same cycle; a pop of an empty FIFO is ignored.
//  Ports       : clk, rst (sync, active-high), i_push/i_data, i_pop/o_data,
//                o_full, o_empty, o_count
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import frame_reader_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PTR_W = idx_width(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/buffer_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_frame_reader
//  Description : Reads a full ping-pong RAM buffer (addresses
//                0..SAMPLES_PER_BUF-1, 1-cycle read latency) on every
//                buffer-ready pulse and streams it on a valid/ready output
//                with first/last markers. A credit-controlled FIFO absorbs
//                RAM latency and back-pressure; a ready pulse arriving while a
//                frame is in progress is dropped and flagged on overrun_o.
//  Ports       : clk_i, rst_i (sync, active-high)
//                buf_ready_pulse_i / buf_ready_id_i   : frame trigger
//                rd_addr_o, rd_en_o, rd_data_i,
//                rd_data_valid_i                      : RAM read port
//                out_valid_o, out_ready_i, out_data_o,
//                out_first_o, out_last_o, out_buf_id_o: sample stream
//                busy_o, overrun_o                    : status
//                overrun_count_o (optional)           : saturating count
//  Options     : define FRAME_READER_OVERRUN_CNT_EN to add overrun_count_o
//  Revision    : 1.0 - initial release
// ============================================================================
module buffer_frame_reader
    import frame_reader_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int SAMPLES_PER_BUF = 256,
    parameter int ADDR_WIDTH      = (SAMPLES_PER_BUF > 1) ? $clog2(SAMPLES_PER_BUF) : 1,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  buf_ready_pulse_i,
    input  logic                  buf_ready_id_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  rd_en_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_data_valid_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_first_o,
    output logic                  out_last_o,
    output logic                  out_buf_id_o,
    output logic                  busy_o,
    output logic                  overrun_o
`ifdef FRAME_READER_OVERRUN_CNT_EN
    ,
    output logic [OVERRUN_CNT_W-1:0] overrun_count_o
`endif
);

    localparam int                  c_TAG_W     = $bits(frame_tag_t);
    localparam int                  c_ENTRY_W   = DATA_WIDTH + c_TAG_W;
    localparam int                  c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                  c_SUM_W     = c_CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);

    frame_state_e          r_state,    w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,     w_addr_nxt;
    logic [ADDR_WIDTH-1:0] r_cap_idx,  w_cap_idx_nxt;
    logic [c_CNT_W-1:0]    r_inflight, w_inflight_nxt;
    logic                  r_buf_id,   w_buf_id_nxt;
    logic                  r_overrun,  w_overrun_nxt;

    logic                  w_rd_en;
    logic                  w_capture;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic [c_SUM_W-1:0]    w_used;
    frame_tag_t            w_push_tag;
    frame_tag_t            w_head_tag;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [c_ENTRY_W-1:0]  w_fifo_din;
    logic [c_ENTRY_W-1:0]  w_fifo_dout;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_CNT_W-1:0]    w_fifo_count;

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_capture),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Returned data only counts when a read is actually outstanding.
    assign w_capture        = rd_data_valid_i && (r_inflight != '0);
    assign w_push_tag.first = (r_cap_idx == '0);
    assign w_push_tag.last  = (r_cap_idx == c_LAST_ADDR);
    assign w_fifo_din       = {rd_data_i, w_push_tag};

    assign w_head_tag  = w_fifo_dout[c_TAG_W-1:0];
    assign w_head_data = w_fifo_dout[c_ENTRY_W-1 -: DATA_WIDTH];
    assign w_pop       = !w_fifo_empty && out_ready_i;

    // Slots committed after this cycle: entries held plus reads in flight,
    // less the entry leaving now. Counting the departing entry lets a
    // 2-entry FIFO sustain one sample per cycle under continuous ready.
    assign w_used      = c_SUM_W'(w_fifo_count) + c_SUM_W'(r_inflight) - c_SUM_W'(w_pop);
    assign w_credit_ok = (w_used < c_SUM_W'(FIFO_DEPTH));

    // ------------------------------------------------------------------------
    // FSM, address counter and credit logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_buf_id_nxt  = r_buf_id;
        w_rd_en       = 1'b0;
        w_overrun_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (buf_ready_pulse_i) begin
                    w_buf_id_nxt = buf_ready_id_i;
                    w_addr_nxt   = '0;
                    w_state_nxt  = READ;
                end
            end
            READ: begin
                w_overrun_nxt = buf_ready_pulse_i;
                w_rd_en       = w_credit_ok;
                if (w_rd_en) begin
                    if (r_addr == c_LAST_ADDR) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                // A pulse here is dropped even in the cycle the frame ends.
                w_overrun_nxt = buf_ready_pulse_i;
                if ((r_inflight == '0) && w_pop && w_head_tag.last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_inflight_nxt = r_inflight + c_CNT_W'(w_rd_en) - c_CNT_W'(w_capture);
        w_cap_idx_nxt  = r_cap_idx;
        if (w_capture) begin
            w_cap_idx_nxt = (r_cap_idx == c_LAST_ADDR) ? '0 : r_cap_idx + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_cap_idx  <= '0;
            r_inflight <= '0;
            r_buf_id   <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_cap_idx  <= w_cap_idx_nxt;
            r_inflight <= w_inflight_nxt;
            r_buf_id   <= w_buf_id_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (sample fields forced low while nothing is presented)
    // ------------------------------------------------------------------------
    assign rd_addr_o    = r_addr;
    assign rd_en_o      = w_rd_en;
    assign out_valid_o  = !w_fifo_empty;
    assign out_data_o   = w_fifo_empty ? '0 : w_head_data;
    assign out_first_o  = !w_fifo_empty && w_head_tag.first;
    assign out_last_o   = !w_fifo_empty && w_head_tag.last;
    assign out_buf_id_o = r_buf_id;
    assign busy_o       = (r_state != IDLE);
    assign overrun_o    = r_overrun;

`ifdef FRAME_READER_OVERRUN_CNT_EN
    logic [OVERRUN_CNT_W-1:0] r_overrun_cnt;

    // Counts alongside the pulse it reports, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overrun_cnt <= '0;
        end else if (w_overrun_nxt && (r_overrun_cnt != '1)) begin
            r_overrun_cnt <= r_overrun_cnt + OVERRUN_CNT_W'(1);
        end
    end

    assign overrun_count_o = r_overrun_cnt;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(rd_data_valid_i && (r_inflight == '0)))
                else $error("buffer_frame_reader: read data returned with no read outstanding");
            assert (!(w_capture && w_fifo_full && !w_pop))
                else $error("buffer_frame_reader: push into full output FIFO");
        end
    end
`endif

endmodule : buffer_frame_reader
`default_nettype wire
